frame_encoder: RTL

FRAME_ENCODER -- requirements
Module: frame_encoder

---
 rtl/frame_pkg.sv | 22 ++
 rtl/ack_timeout_counter.sv | 38 +++
 rtl/frame_encoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame encoder.
// Also holds the payload clamp rule used by the top level.
package frame_pkg;

    localparam logic [7:0] SYNC_WORD   = 8'hFF;
    localparam logic [7:0] CLAMP_VALUE = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_CTRL,
        S_WAIT_ACK,
        S_STREAM,
        S_TERM
    } state_e;

    // The sync word is reserved as a frame delimiter, so payload never carries it.
    function automatic logic [7:0] clamp_sample(input logic [7:0] s);
        return (s == SYNC_WORD) ? CLAMP_VALUE : s;
    endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// Counts cycles spent waiting for the control-word echo.
// Raises expired while enabled once ACK_TIMEOUT-1 has been reached.
module ack_timeout_counter #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/frame_encoder.sv
// Frames a sample stream for the controller link: sync, control word, echo
// handshake, clamped payload, then a sync terminator.
module frame_encoder
    import frame_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ctrl_word,
    input  logic             abort,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             sample_last,
    output logic             sample_ready,
    output logic [7:0]       data_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [7:0]       data_ack,
    input  logic             ack_strobe,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] clamp_cnt
);

    state_e           state_q, state_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             tail_q, tail_d;
    logic [CNT_W-1:0] clamp_q, clamp_d;

    logic xfer;
    logic accept;
    logic tmr_clear;
    logic tmr_expired;

    ack_timeout_counter #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (state_q == S_WAIT_ACK),
        .expired (tmr_expired)
    );

    assign xfer         = valid_q && out_ready;
    assign sample_ready = (state_q == S_STREAM) && (!valid_q || out_ready);
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        valid_d   = valid_q;
        tail_d    = tail_q;
        clamp_d   = clamp_q;
        tmr_clear = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctrl_d  = ctrl_word;
                    clamp_d = '0;
                    data_d  = SYNC_WORD;
                    valid_d = 1'b1;
                    tail_d  = 1'b0;
                    state_d = S_SYNC;
                end
            end

            S_SYNC: begin
                if (abort) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    data_d  = ctrl_q;
                    state_d = S_CTRL;
                end
            end

            S_CTRL: begin
                if (abort) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    valid_d   = 1'b0;
                    tmr_clear = 1'b1;
                    state_d   = S_WAIT_ACK;
                end
            end

            // An ack that lands on the expiry cycle still counts as on time.
            S_WAIT_ACK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ack_strobe) begin
                    if (data_ack == ctrl_q) begin
                        state_d = S_STREAM;
                    end else begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmr_expired) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_STREAM: begin
                if (accept) begin
                    data_d  = clamp_sample(sample_in);
                    valid_d = 1'b1;
                    if ((sample_in == SYNC_WORD) && (clamp_q != '1)) begin
                        clamp_d = clamp_q + 1'b1;
                    end
                end else if (xfer) begin
                    valid_d = 1'b0;
                end
                if (abort || (accept && sample_last)) begin
                    state_d = S_TERM;
                end
            end

            // tail_q marks that the output register holds the terminator, not payload.
            S_TERM: begin
                if (!valid_q) begin
                    data_d  = SYNC_WORD;
                    valid_d = 1'b1;
                    tail_d  = 1'b1;
                end else if (xfer) begin
                    if (tail_q) begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        tail_d  = 1'b0;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        data_d = SYNC_WORD;
                        tail_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            tail_q  <= 1'b0;
            clamp_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tail_q  <= tail_d;
            clamp_q <= clamp_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign clamp_cnt = clamp_q;

endmodule
